// File: rtl/song_reader.sv
// song_reader: walks a song held in an external synchronous ROM and hands each
// note/duration pair to note_player with a one-cycle load_new_note strobe.
// Optional build macro SONG_LOOP_EN: the song replays from entry 0 at its end
// and song_done pulses for one cycle instead of staying high.
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song_sel,
  input  logic                           new_song,
  input  logic                           done_with_note,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [11:0]                    rom_data,
  output logic [5:0]                     note_to_load,
  output logic [5:0]                     duration_to_load,
  output logic                           load_new_note,
  output logic                           song_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_LOAD,
    ST_WAIT,
    ST_END
  } state_t;

  state_t               state, state_next;
  logic [SONG_BITS-1:0] song, song_next;
  logic [NOTE_BITS-1:0] index, index_next;
  logic                 latch;
  logic                 song_end;
  logic                 done_next;

  // Next-state, next song/index and strobe decisions.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_next = state;
    song_next  = song;
    index_next = index;
    latch      = 1'b0;
    song_end   = 1'b0;
`ifdef SONG_LOOP_EN
    done_next  = 1'b0;
`else
    done_next  = song_done;
`endif

    if (new_song) begin
      // Restart wins over everything, including a done_with_note this cycle.
      song_next  = song_sel;
      index_next = '0;
      done_next  = 1'b0;
      state_next = ST_FETCH;
    end else begin
      unique case (state)
        ST_IDLE:  if (play) state_next = ST_FETCH;
        ST_FETCH: if (play) state_next = ST_CHECK;
        ST_CHECK: begin
          if (play) begin
            if (rom_data[5:0] == 6'd0) begin
              song_end = 1'b1;
            end else begin
              latch      = 1'b1;
              state_next = ST_LOAD;
            end
          end
        end
        ST_LOAD:  state_next = ST_WAIT;
        ST_WAIT: begin
          if (done_with_note) begin
            if (index == '1) begin
              song_end = 1'b1;
            end else begin
              index_next = index + NOTE_BITS'(1);
              state_next = ST_FETCH;
            end
          end
        end
        ST_END:   state_next = ST_END;
        default:  state_next = ST_IDLE;
      endcase

      if (song_end) begin
        done_next = 1'b1;
`ifdef SONG_LOOP_EN
        index_next = '0;
        state_next = ST_FETCH;
`else
        state_next = ST_END;
`endif
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Datapath registers; rom_addr is loaded from the next song/index so the
  // address is already stable during the FETCH cycle that follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      song             <= '0;
      index            <= '0;
      rom_addr         <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      song          <= song_next;
      index         <= index_next;
      rom_addr      <= {song_next, index_next};
      load_new_note <= latch;
      song_done     <= done_next;
      if (latch) begin
        note_to_load     <= rom_data[11:6];
        duration_to_load <= rom_data[5:0];
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: scoreboard bench for song_reader. A synchronous ROM model
// supplies four songs; expected note/duration pairs are queued when a load is
// provoked and compared when load_new_note appears.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song_sel;
  logic        new_song;
  logic        done_with_note;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        song_done;

  logic [11:0] rom [0:127];
  logic [11:0] sb_q [$];
  int          n_checks = 0;
  int          n_fails  = 0;

  song_reader dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song_sel         (song_sel),
    .new_song         (new_song),
    .done_with_note   (done_with_note),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input int n, input string tag);
    repeat (n) tick();
    check(tag, 32'(load_new_note), 32'd1);
  endtask

  task automatic pulse_done();
    done_with_note = 1'b1;
    tick();
    done_with_note = 1'b0;
  endtask

  task automatic start_song(input logic [1:0] s, input logic p);
    song_sel = s;
    new_song = 1'b1;
    play     = p;
    tick();
    new_song = 1'b0;
  endtask

  // Scoreboard: compare every strobe against the oldest expected pair.
  always @(negedge clk) begin
    if (!reset && load_new_note) begin
      if (sb_q.size() == 0) begin
        check("unexpected_load", {20'd0, note_to_load, duration_to_load}, 32'hfff);
      end else begin
        check("load_data", {20'd0, note_to_load, duration_to_load}, {20'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    rom[0]  = {6'd10, 6'd2};
    rom[1]  = {6'd22, 6'd5};
    rom[2]  = {6'd0,  6'd0};
    rom[32] = {6'd5,  6'd3};
    rom[64] = {6'd33, 6'd7};
    rom[65] = {6'd34, 6'd8};
    rom[66] = {6'd0,  6'd0};
    for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'(2 * i + 1)};

    reset = 1'b1; play = 1'b0; song_sel = 2'd0; new_song = 1'b0; done_with_note = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_load", 32'(load_new_note), 32'd0);
    check("rst_done", 32'(song_done), 32'd0);
    check("rst_note", {26'd0, note_to_load}, 32'd0);

    // Stray done in IDLE: nothing moves.
    pulse_done();
    tick();
    check("idle_stray_addr", 32'(rom_addr), 32'd0);

    // Basic play: song0.
    play = 1'b1;
    sb_q.push_back({6'd10, 6'd2});
    expect_load(3, "first_latency");
    tick();
    check("one_strobe", 32'(load_new_note), 32'd0);
    pulse_done();
    check("addr_after_done", 32'(rom_addr), 32'd1);
    sb_q.push_back({6'd22, 6'd5});
    expect_load(2, "second_latency");
    tick();
    pulse_done();
    tick(); tick();
    check("marker_done", 32'(song_done), 32'd1);
`ifdef SONG_LOOP_EN
    tick();
    check("loop_done_pulse", 32'(song_done), 32'd0);
    sb_q.push_back({6'd10, 6'd2});
    tick();
    check("loop_reload", 32'(load_new_note), 32'd1);
`else
    pulse_done();
    repeat (4) tick();
    check("end_sticky", 32'(song_done), 32'd1);
    check("end_no_strobe", 32'(load_new_note), 32'd0);
    check("end_stray_addr", 32'(rom_addr), 32'd2);
`endif

    // Pause in FETCH.
    start_song(2'd0, 1'b0);
    check("new_song_clears_done", 32'(song_done), 32'd0);
    repeat (10) tick();
    check("pause_addr", 32'(rom_addr), 32'd0);
    check("pause_load", 32'(load_new_note), 32'd0);
    play = 1'b1;
    sb_q.push_back({6'd10, 6'd2});
    expect_load(2, "resume_latency");
    tick();

    // Song switch in WAIT together with done_with_note.
    song_sel = 2'd2; new_song = 1'b1; done_with_note = 1'b1;
    tick();
    new_song = 1'b0; done_with_note = 1'b0;
    check("switch_addr", 32'(rom_addr), 32'h40);
    sb_q.push_back({6'd33, 6'd7});
    expect_load(2, "switch_latency");
    tick();
    pulse_done();
    check("switch_next_addr", 32'(rom_addr), 32'h41);
    sb_q.push_back({6'd34, 6'd8});
    expect_load(2, "switch_second");
    tick();
    pulse_done();
    tick(); tick();
    check("song2_done", 32'(song_done), 32'd1);

    // Stray done in FETCH, CHECK and LOAD.
    start_song(2'd1, 1'b0);
    pulse_done();
    check("fetch_stray_addr", 32'(rom_addr), 32'h20);
    tick();
    check("fetch_stray_load", 32'(load_new_note), 32'd0);
    play = 1'b1;
    pulse_done();
    check("check_stray_addr", 32'(rom_addr), 32'h20);
    sb_q.push_back({6'd5, 6'd3});
    pulse_done();
    check("stray_load", 32'(load_new_note), 32'd1);
    pulse_done();
    check("load_stray_addr", 32'(rom_addr), 32'h20);
    repeat (3) tick();
    check("wait_no_strobe", 32'(load_new_note), 32'd0);

    // Overflow: song3 has no end marker.
    start_song(2'd3, 1'b1);
    for (int i = 0; i < 32; i++) begin
      sb_q.push_back({6'(i + 1), 6'(2 * i + 1)});
      expect_load(2, "ovf_load");
      tick();
      pulse_done();
      if (i < 31) check("ovf_addr", 32'(rom_addr), 32'(7'h60 + 7'(i + 1)));
    end
    check("ovf_done", 32'(song_done), 32'd1);
`ifdef SONG_LOOP_EN
    tick();
    check("ovf_done_pulse", 32'(song_done), 32'd0);
    sb_q.push_back({6'd1, 6'd1});
    tick();
    check("ovf_replay", 32'(load_new_note), 32'd1);
    tick();
`else
    repeat (4) tick();
    check("ovf_sticky", 32'(song_done), 32'd1);
    check("ovf_no_strobe", 32'(load_new_note), 32'd0);
`endif

    // Asynchronous reset in the middle of WAIT.
    start_song(2'd0, 1'b1);
    sb_q.push_back({6'd10, 6'd2});
    expect_load(2, "pre_reset_load");
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_addr", 32'(rom_addr), 32'd0);
    check("async_outs", {20'd0, note_to_load, duration_to_load}, 32'd0);
    check("async_load", 32'(load_new_note), 32'd0);
    check("async_done", 32'(song_done), 32'd0);
    play = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", 32'(load_new_note), 32'd0);
    play = 1'b1;
    sb_q.push_back({6'd10, 6'd2});
    expect_load(3, "post_reset_latency");
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
